// File: rtl/dev_cnt_lcd_fifo_pkg.sv
// Shared definitions for the PICO16a character-LCD peripheral: register map,
// STATUS/CTRL bit positions, timing FSM states and the FIFO entry payload.
package dev_cnt_lcd_fifo_pkg;

   localparam logic [3:0] OFS_DATA   = 4'h0;
   localparam logic [3:0] OFS_CMD    = 4'h1;
   localparam logic [3:0] OFS_STATUS = 4'h2;
   localparam logic [3:0] OFS_CTRL   = 4'h3;

   localparam int unsigned ST_OVF   = 15;
   localparam int unsigned ST_BUSY  = 14;
   localparam int unsigned ST_EMPTY = 13;
   localparam int unsigned ST_FULL  = 12;

   localparam int unsigned CTRL_FLUSH   = 0;
   localparam int unsigned CTRL_CLR_OVF = 1;
   localparam int unsigned CTRL_IRQ_EN  = 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_PULSE = 3'd2,
      S_HOLD  = 3'd3,
      S_EXEC  = 3'd4
   } lcd_state_e;

   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } lcd_entry_t;

   // Clear display / return home commands need the long execution wait.
   function automatic logic is_long_cmd(input lcd_entry_t e);
      return !e.rs && (e.data[7:2] == 6'd0) && (e.data != 8'h00);
   endfunction

endpackage

// File: rtl/dev_cnt_lcd_fifo_cmd_fifo.sv
// Synchronous show-ahead command FIFO of {rs,data} entries; flush empties it
// immediately and overrides any push or pop in the same cycle.
module dev_cnt_lcd_fifo_cmd_fifo
   import dev_cnt_lcd_fifo_pkg::*;
#(
   parameter int unsigned FIFO_AW = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  lcd_entry_t       din,
   output lcd_entry_t       dout,
   output logic [FIFO_AW:0] level,
   output logic             full,
   output logic             empty
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;

   lcd_entry_t       mem_q [DEPTH];
   logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
   logic             do_push, do_pop;

   assign level   = wr_ptr_q - rd_ptr_q;
   assign empty   = (level == '0);
   assign full    = (level == (FIFO_AW+1)'(DEPTH));
   assign do_pop  = pop && !empty && !flush;
   // A pop in the same cycle frees the slot a push to a full FIFO needs.
   assign do_push = push && !flush && (!full || do_pop);
   assign dout    = mem_q[rd_ptr_q[FIFO_AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (FIFO_AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (FIFO_AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= din;
   end

endmodule

// File: rtl/dev_cnt_lcd_fifo.sv
// PICO16a bus peripheral feeding an HD44780-style LCD through a command FIFO
// and a timing FSM. Optional LCD_IRQ_EN adds the lcd_irq "drained" output.
module dev_cnt_lcd_fifo
   import dev_cnt_lcd_fifo_pkg::*;
#(
   parameter logic [15:0] BASE_ADRS   = 16'h8040,
   parameter int unsigned SPACE       = 5,
   parameter int unsigned FIFO_AW     = 4,
   parameter int unsigned T_SETUP     = 2,
   parameter int unsigned T_PULSE     = 12,
   parameter int unsigned T_HOLD      = 12,
   parameter int unsigned T_EXEC      = 2000,
   parameter int unsigned T_EXEC_LONG = 82000
) (
   input  logic        cpu_clk,
   input  logic        rst,
   input  logic [15:0] adrs,
   input  logic [15:0] from_cpu,
   input  logic        we,
   output logic [15:0] to_cpu,
   output logic [7:0]  LCD_DATA,
   output logic        LCD_RW,
   output logic        LCD_EN,
   output logic        LCD_RS
`ifdef LCD_IRQ_EN
   ,
   output logic        lcd_irq
`endif
);

   localparam int unsigned CW = $clog2(T_EXEC_LONG + 1);

   logic             cs, bus_wr, bus_rd, push_req, ctrl_wr, flush;
   logic [3:0]       offset;
   lcd_entry_t       fifo_din, fifo_dout;
   logic [FIFO_AW:0] fifo_level;
   logic             fifo_full, fifo_empty, fifo_pop;

   lcd_state_e       state_q;
   logic [CW-1:0]    cnt_q;
   lcd_entry_t       out_q;
   logic             en_q;
   logic             ovf_q;
   logic             irq_en_bit;
   logic [15:0]      rd_mux, rd_data_q;
   logic             rd_valid_q;
   logic             unused_bits;

   // Bus decode
   assign cs       = (adrs[15:SPACE] == BASE_ADRS[15:SPACE]);
   assign offset   = adrs[3:0];
   assign bus_wr   = cs && we;
   assign bus_rd   = cs && !we;
   assign push_req = bus_wr && ((offset == OFS_DATA) || (offset == OFS_CMD));
   assign ctrl_wr  = bus_wr && (offset == OFS_CTRL);
   assign flush    = ctrl_wr && from_cpu[CTRL_FLUSH];
   assign fifo_din = '{rs: (offset == OFS_DATA), data: from_cpu[7:0]};
   assign fifo_pop = (state_q == S_IDLE) && !fifo_empty && !flush;

   assign unused_bits = ^{adrs, from_cpu};

   dev_cnt_lcd_fifo_cmd_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
      .clk   (cpu_clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (fifo_pop),
      .flush (flush),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Timing FSM: one down-counter times every phase; EN is never cut short.
   always_ff @(posedge cpu_clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         out_q   <= '0;
         en_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (fifo_pop) begin
                  out_q   <= fifo_dout;
                  cnt_q   <= CW'(T_SETUP - 1);
                  state_q <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (cnt_q == '0) begin
                  en_q    <= 1'b1;
                  cnt_q   <= CW'(T_PULSE - 1);
                  state_q <= S_PULSE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_PULSE: begin
               if (cnt_q == '0) begin
                  en_q    <= 1'b0;
                  cnt_q   <= CW'(T_HOLD - 1);
                  state_q <= S_HOLD;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_HOLD: begin
               if (cnt_q == '0) begin
                  cnt_q   <= is_long_cmd(out_q) ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
                  state_q <= S_EXEC;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_EXEC: begin
               if (cnt_q == '0) state_q <= S_IDLE;
               else             cnt_q   <= cnt_q - CW'(1);
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge cpu_clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
      end else if (ctrl_wr && from_cpu[CTRL_CLR_OVF]) begin
         ovf_q <= 1'b0;
      end else if (push_req && !flush && fifo_full && !fifo_pop) begin
         ovf_q <= 1'b1;
      end
   end

`ifdef LCD_IRQ_EN
   logic irq_en_q, irq_q;

   always_ff @(posedge cpu_clk or negedge rst) begin
      if (!rst) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (ctrl_wr) irq_en_q <= from_cpu[CTRL_IRQ_EN];
         irq_q <= irq_en_q && fifo_empty && (state_q == S_IDLE);
      end
   end

   assign irq_en_bit = irq_en_q;
   assign lcd_irq    = irq_q;
`else
   assign irq_en_bit = 1'b0;
`endif

   always_comb begin
      rd_mux = '0;
      case (offset)
         OFS_STATUS: begin
            rd_mux[ST_OVF]      = ovf_q;
            rd_mux[ST_BUSY]     = (state_q != S_IDLE);
            rd_mux[ST_EMPTY]    = fifo_empty;
            rd_mux[ST_FULL]     = fifo_full;
            rd_mux[FIFO_AW:0]   = fifo_level;
         end
         OFS_CTRL: rd_mux[CTRL_IRQ_EN] = irq_en_bit;
         default: rd_mux = '0;
      endcase
   end

   // Read data lands one cycle after the bus read strobe.
   always_ff @(posedge cpu_clk or negedge rst) begin
      if (!rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= bus_rd;
         if (bus_rd) rd_data_q <= rd_mux;
      end
   end

   assign to_cpu   = rd_valid_q ? rd_data_q : 16'bz;
   assign LCD_DATA = out_q.data;
   assign LCD_RS   = out_q.rs;
   assign LCD_EN   = en_q;
   assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_dev_cnt_lcd_fifo.sv
// Self-checking bench for dev_cnt_lcd_fifo: register table, directed LCD
// timing sequences and a randomized run against a schedule-level model.
module tb_dev_cnt_lcd_fifo;

   localparam int unsigned TS = 2, TP = 3, TH = 2, TE = 5, TL = 20, AW = 2, DEPTH = 4;
   localparam logic [15:0] A_DATA = 16'h8040, A_CMD = 16'h8041, A_STAT = 16'h8042;
   localparam logic [15:0] A_CTRL = 16'h8043, A_IDLE = 16'h0000;
   localparam logic [15:0] RELEASED = 16'hFFFF;

   logic        cpu_clk, rst, we;
   logic [15:0] adrs, from_cpu;
   wire  [15:0] to_cpu;
   logic [7:0]  LCD_DATA;
   logic        LCD_RW, LCD_EN, LCD_RS;
`ifdef LCD_IRQ_EN
   logic        lcd_irq;
`endif

   pullup pu_to_cpu (to_cpu);

   dev_cnt_lcd_fifo #(
      .BASE_ADRS(16'h8040), .SPACE(5), .FIFO_AW(AW), .T_SETUP(TS), .T_PULSE(TP),
      .T_HOLD(TH), .T_EXEC(TE), .T_EXEC_LONG(TL)
   ) dut (
      .cpu_clk(cpu_clk), .rst(rst), .adrs(adrs), .from_cpu(from_cpu), .we(we),
      .to_cpu(to_cpu), .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
      .LCD_RS(LCD_RS)
`ifdef LCD_IRQ_EN
      , .lcd_irq(lcd_irq)
`endif
   );

   int n_cmp = 0, n_bad = 0, edge_n = 0;

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // EN monitor: every completed pulse must last TP cycles; rises are logged.
   int         rise_edge_q[$];
   logic [8:0] rise_val_q[$];
   int         en_run = 0;
   logic       en_prev = 1'b0;

   always @(posedge cpu_clk) begin
      edge_n++;
      #1;
      if (!rst) begin
         en_run  = 0;
         en_prev = 1'b0;
      end else begin
         if (LCD_EN) begin
            if (!en_prev) begin
               rise_edge_q.push_back(edge_n);
               rise_val_q.push_back({LCD_RS, LCD_DATA});
            end
            en_run++;
         end else if (en_prev) begin
            chk("en_pulse_width", 32'(en_run), 32'(TP));
            en_run = 0;
         end
         en_prev = LCD_EN;
      end
   end

   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [15:0] d, output int c);
      adrs = a; from_cpu = d; we = 1'b1;
      tick();
      c = edge_n;
      we = 1'b0; adrs = A_IDLE; from_cpu = '0;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [15:0] v, output int c);
      adrs = a; we = 1'b0;
      tick();
      c = edge_n;
      adrs = A_IDLE;
      v = to_cpu;
   endtask

   task automatic wait_rise(input string nm, output int e);
      logic prev;
      prev = LCD_EN;
      e = -1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (LCD_EN && !prev) begin
            e = edge_n;
            break;
         end
         prev = LCD_EN;
      end
      if (e < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: got no EN rise in 100 cycles, expected a rise", nm);
      end
   endtask

   // Schedule model: each accepted byte is popped at the later of (push+1)
   // and (previous pop + previous transfer length + 1 idle cycle).
   typedef struct { int c; int p; int tot; logic rs; logic [7:0] d; } acc_t;
   acc_t acc[$];
   bit   m_ovf;

   function automatic int m_level(input int c);
      int n = 0;
      foreach (acc[k]) if (acc[k].c < c && acc[k].p >= c) n++;
      return n;
   endfunction

   function automatic bit m_busy(input int c);
      foreach (acc[k]) if (c >= acc[k].p + 1 && c <= acc[k].p + acc[k].tot) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_pop_at(input int c);
      foreach (acc[k]) if (acc[k].p == c) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_push(input int c, input logic rs, input logic [7:0] d);
      acc_t a;
      int   ex;
      if (m_level(c) < DEPTH || m_pop_at(c)) begin
         ex = (!rs && d >= 8'd1 && d <= 8'd3) ? TL : TE;
         a.c = c; a.rs = rs; a.d = d;
         a.tot = TS + TP + TH + ex;
         a.p = c + 1;
         if (acc.size() > 0 && acc[$].p + acc[$].tot + 1 > a.p) a.p = acc[$].p + acc[$].tot + 1;
         acc.push_back(a);
      end else begin
         m_ovf = 1'b1;
      end
   endtask

   function automatic logic [15:0] m_status(input int c);
      logic [15:0] s;
      int lvl;
      lvl = m_level(c);
      s = '0;
      s[15] = m_ovf;
      s[14] = m_busy(c);
      s[13] = (lvl == 0);
      s[12] = (lvl == DEPTH);
      s[2:0] = 3'(lvl);
      return s;
   endfunction

   typedef struct { logic [15:0] a; logic [15:0] exp; string nm; } rd_vec_t;
   rd_vec_t tbl[8];

   initial begin
      logic [15:0] v, ctrl_exp;
      int c, e, r1, r2, n, kind, gap;
      logic rs;
      logic [7:0] d;

      rst = 1'b0; we = 1'b0; adrs = A_IDLE; from_cpu = '0;
      #1;
      chk("reset_en", 32'(LCD_EN), 0);
      chk("reset_rs", 32'(LCD_RS), 0);
      chk("reset_data", 32'(LCD_DATA), 0);
      chk("reset_rw", 32'(LCD_RW), 0);
      chk("reset_to_cpu", 32'(to_cpu), 32'(RELEASED));
      repeat (3) tick();
      rst = 1'b1;
      tick();

      tbl[0] = '{16'h8040, 16'h0000, "rd_data"};
      tbl[1] = '{16'h8041, 16'h0000, "rd_cmd"};
      tbl[2] = '{16'h8042, 16'h2000, "rd_status"};
      tbl[3] = '{16'h8043, 16'h0000, "rd_ctrl"};
      tbl[4] = '{16'h804F, 16'h0000, "rd_ofs_f"};
      tbl[5] = '{16'h805A, 16'h0000, "rd_ofs_a_hi"};
      tbl[6] = '{16'h8060, RELEASED, "rd_above_window"};
      tbl[7] = '{16'h803F, RELEASED, "rd_below_window"};
      foreach (tbl[i]) begin
         adrs = tbl[i].a; we = 1'b0;
         #1;
         chk({tbl[i].nm, "_early"}, 32'(to_cpu), 32'(RELEASED));
         tick();
         adrs = A_IDLE;
         chk(tbl[i].nm, 32'(to_cpu), 32'(tbl[i].exp));
         tick();
         chk({tbl[i].nm, "_release"}, 32'(to_cpu), 32'(RELEASED));
      end

`ifdef LCD_IRQ_EN
      ctrl_exp = 16'h0004;
`else
      ctrl_exp = 16'h0000;
`endif
      bus_write(A_CTRL, 16'h0004, c);
      bus_read(A_CTRL, v, c);
      chk("ctrl_irq_en_read", 32'(v), 32'(ctrl_exp));
`ifdef LCD_IRQ_EN
      tick();
      chk("irq_idle_empty", 32'(lcd_irq), 1);
`endif
      bus_write(A_CTRL, 16'h0000, c);

      // Single DATA byte
      bus_write(A_DATA, 16'h0041, c);
      wait_rise("d41_rise", e);
      chk("d41_rise_delay", 32'(e - c), 3);
      chk("d41_rs", 32'(LCD_RS), 1);
      chk("d41_data", 32'(LCD_DATA), 32'h41);
      bus_read(A_STAT, v, c);
      chk("d41_status_busy", 32'(v), 32'h6000);
      repeat (20) tick();
      bus_read(A_STAT, v, c);
      chk("d41_status_idle", 32'(v), 32'h2000);

      // Clear display then data: long exec between rises
      bus_write(A_CMD, 16'h0001, c);
      bus_write(A_DATA, 16'h0042, n);
      wait_rise("clr_rise", r1);
      chk("clr_rise_delay", 32'(r1 - c), 3);
      chk("clr_rs", 32'(LCD_RS), 0);
      chk("clr_data", 32'(LCD_DATA), 32'h01);
      wait_rise("d42_rise", r2);
      chk("clr_to_d42_gap", 32'(r2 - r1), 32'(TS + TP + TH + TL + 1));
      chk("d42_data", 32'({LCD_RS, LCD_DATA}), 32'h142);
      repeat (15) tick();

      // Function-set command gets the short exec only
      bus_write(A_CMD, 16'h0038, c);
      bus_write(A_DATA, 16'h0043, n);
      wait_rise("fs_rise", r1);
      wait_rise("d43_rise", r2);
      chk("fs_to_d43_gap", 32'(r2 - r1), 32'(TS + TP + TH + TE + 1));
      repeat (15) tick();

      // Overflow: six back-to-back pushes while entry 1 is in flight
      rise_edge_q.delete(); rise_val_q.delete();
      for (int i = 0; i < 6; i++) bus_write(A_DATA, 16'(16'h0050 + i), c);
      bus_read(A_STAT, v, c);
      chk("ovf_status", 32'(v), 32'hD004);
      bus_write(A_CTRL, 16'h0002, c);
      bus_read(A_STAT, v, c);
      chk("ovf_cleared_status", 32'(v), 32'h5004);
      repeat (80) tick();
      chk("ovf_transfers", 32'(rise_val_q.size()), 5);
      for (int i = 0; i < 5 && i < rise_val_q.size(); i++)
         chk("ovf_transfer_val", 32'(rise_val_q[i]), 32'(9'h150 + i));

      // Flush during PULSE
      rise_edge_q.delete(); rise_val_q.delete();
      bus_write(A_DATA, 16'h0061, c);
      bus_write(A_DATA, 16'h0062, c);
      bus_write(A_DATA, 16'h0063, c);
      wait_rise("flush_rise", e);
      bus_write(A_CTRL, 16'h0001, c);
      chk("flush_en_still_high", 32'(LCD_EN), 1);
      bus_read(A_STAT, v, c);
      chk("flush_status", 32'(v), 32'h6000);
      repeat (40) tick();
      chk("flush_transfers", 32'(rise_val_q.size()), 1);
      bus_read(A_STAT, v, c);
      chk("flush_status_idle", 32'(v), 32'h2000);

      // Reset during PULSE
      bus_write(A_DATA, 16'h0071, c);
      bus_write(A_DATA, 16'h0072, c);
      wait_rise("rst_rise", e);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_en_async", 32'(LCD_EN), 0);
      chk("rst_lcd_bus", 32'({LCD_RS, LCD_DATA}), 0);
      tick();
      @(posedge cpu_clk);
      #3;
      rst = 1'b1;
      tick();
      bus_read(A_STAT, v, c);
      chk("rst_status", 32'(v), 32'h2000);
      rise_edge_q.delete(); rise_val_q.delete();
      repeat (40) tick();
      chk("rst_bytes_lost", 32'(rise_val_q.size()), 0);

      // Randomized traffic against the schedule model
      acc.delete(); m_ovf = 1'b0;
      rise_edge_q.delete(); rise_val_q.delete();
      for (int op = 0; op < 90; op++) begin
         gap = $urandom_range(0, 6);
         repeat (gap) tick();
         kind = $urandom_range(0, 9);
         if (kind <= 5) begin
            rs = 1'($urandom_range(0, 1));
            if (!rs && $urandom_range(0, 2) == 0) d = 8'($urandom_range(1, 3));
            else d = 8'($urandom);
            bus_write(rs ? A_DATA : A_CMD, {8'($urandom), d}, c);
            m_push(c, rs, d);
         end else if (kind <= 8) begin
            bus_read(A_STAT, v, c);
            chk("rand_status", 32'(v), 32'(m_status(c)));
         end else begin
            bus_write(A_CTRL, 16'h0002, c);
            m_ovf = 1'b0;
         end
      end
      n = 0;
      foreach (acc[k]) if (acc[k].p + acc[k].tot > n) n = acc[k].p + acc[k].tot;
      n = n + 5 - edge_n;
      repeat ((n > 0) ? n : 1) tick();
      chk("rand_transfer_count", 32'(rise_edge_q.size()), 32'(acc.size()));
      for (int i = 0; i < acc.size() && i < rise_edge_q.size(); i++) begin
         chk("rand_rise_edge", 32'(rise_edge_q[i]), 32'(acc[i].p + TS));
         chk("rand_rise_val", 32'(rise_val_q[i]), 32'({acc[i].rs, acc[i].d}));
      end
      bus_read(A_STAT, v, c);
      chk("rand_final_status", 32'(v), 32'(m_status(c)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
